// File: rtl/clock_pkg.sv
// Shared definitions for the clock/alarm front panel: FSM encodings and timing defaults
// used by both the pushbutton debouncer and the pulse stretcher.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ON   = 2'b01,
      ST_GAP  = 2'b10
   } state_t;

   localparam int CLK_HZ          = 50000000;
   localparam int DEBOUNCE_CYCLES = 2000000;   // 40 ms at CLK_HZ

endpackage

// File: rtl/tone_gen.sv
// Piezo square-wave generator: toggles every TONE_HALF cycles while en is high, held at 0 otherwise.
// Only compiled into the design when PULSE_STRETCHER_TONE_EN is defined.
`ifdef PULSE_STRETCHER_TONE_EN
module tone_gen #(
   parameter int TONE_HALF = 12500
) (
   input  logic CLK,
   input  logic clear,
   input  logic en,
   output logic tone_out
);

   localparam int HW = (TONE_HALF < 2) ? 1 : $clog2(TONE_HALF);
   localparam logic [HW-1:0] HALF_LAST = HW'(TONE_HALF - 1);
   localparam logic [HW-1:0] HALF_ONE  = HW'(1);

   logic [HW-1:0] half_q;
   logic          tone_q;

   always_ff @(posedge CLK or posedge clear) begin
      if (clear) begin
         half_q <= '0;
         tone_q <= 1'b0;
      end else if (!en) begin
         half_q <= '0;
         tone_q <= 1'b0;
      end else if (half_q == HALF_LAST) begin
         half_q <= '0;
         tone_q <= ~tone_q;
      end else begin
         half_q <= half_q + HALF_ONE;
      end
   end

   // Masked with en so the tone stops on the same edge the indication ends.
   assign tone_out = tone_q & en;

endmodule
`endif

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into fixed ON/GAP indications, queuing overlapping events.
// Define PULSE_STRETCHER_TONE_EN to add the tone_out piezo drive (tone_gen).
module pulse_stretcher
   import clock_pkg::*;
#(
   parameter int ON_CYCLES  = DEBOUNCE_CYCLES,
   parameter int GAP_CYCLES = DEBOUNCE_CYCLES,
   parameter int CNT_W      = 21,
   parameter int PEND_W     = 3
`ifdef PULSE_STRETCHER_TONE_EN
   ,parameter int TONE_HALF = 12500
`endif
) (
   input  logic              CLK,
   input  logic              clear,
   input  logic              pulse_in,
   output logic              out_level,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
`ifdef PULSE_STRETCHER_TONE_EN
   ,output logic             tone_out
`endif
);

   localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic              out_q;
   logic              cnt_zero, pend_inc, pend_dec;

   assign cnt_zero = (cnt_q == '0);

   // An event starts directly from IDLE, or at GAP exit when nothing is queued; otherwise it queues.
   always_comb begin
      pend_dec = (state_q == ST_GAP) && cnt_zero && (pend_q != '0);
      pend_inc = pulse_in &&
                 ((state_q == ST_ON) ||
                  ((state_q == ST_GAP) && !(cnt_zero && (pend_q == '0))));
      pend_d   = pend_q;
      ovf_d    = ovf_q;
      if (pend_inc && !pend_dec) begin
         if (pend_q == PEND_MAX) ovf_d  = 1'b1;
         else                    pend_d = pend_q + PEND_ONE;
      end else if (pend_dec && !pend_inc) begin
         pend_d = pend_q - PEND_ONE;
      end
   end

   always_ff @(posedge CLK or posedge clear) begin
      if (clear) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         out_q   <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         case (state_q)
            ST_IDLE: begin
               if (pulse_in) begin
                  state_q <= ST_ON;
                  cnt_q   <= ON_LOAD;
                  out_q   <= 1'b1;
               end
            end
            ST_ON: begin
               if (cnt_zero) begin
                  state_q <= ST_GAP;
                  cnt_q   <= GAP_LOAD;
                  out_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            ST_GAP: begin
               if (!cnt_zero) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end else if ((pend_q != '0) || pulse_in) begin
                  state_q <= ST_ON;
                  cnt_q   <= ON_LOAD;
                  out_q   <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               out_q   <= 1'b0;
            end
         endcase
      end
   end

   assign out_level = out_q;
   assign busy      = (state_q != ST_IDLE);
   assign pending   = pend_q;
   assign overflow  = ovf_q;

`ifdef PULSE_STRETCHER_TONE_EN
   tone_gen #(
      .TONE_HALF (TONE_HALF)
   ) u_tone (
      .CLK      (CLK),
      .clear    (clear),
      .en       (state_q == ST_ON),
      .tone_out (tone_out)
   );
`endif

endmodule
